// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS core: one shared ALU and one ready-stalled memory port, sequenced by a
// two-process FSM. Memory request outputs are registered from the next-state decision.
module mips_multicycle_cpu #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          NREGS    = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       pc_out,
  output logic [31:0]       instret
);
  localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] OP_R   = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, ir, a, b, alu_out, instret_q;
  logic [31:0] gpr [NREGS];
  logic [31:0] rs_val, rt_val, alu_res, imm_s, addr_next, wdata_next;
  logic        req_next, we_next, legal, taken, accept, wb_en;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, wb_dst;
  logic        unused_shamt;

  assign op           = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign fn           = ir[5:0];
  assign imm_s        = {{16{ir[15]}}, ir[15:0]};
  assign unused_shamt = ^ir[10:6];
  assign accept       = mem_req && mem_ready;
  assign taken        = (op == OP_BEQ) ? (a == b) : (a != b);
  assign wb_dst       = (op == OP_R) ? rd : rt;
  assign wb_en        = (state == S_WB) && (wb_dst != 5'd0) && (int'(wb_dst) < NREGS);

  // Register indices beyond NREGS, and $0, read as zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0 && int'(rs) < NREGS) rs_val = gpr[rs[RI_W-1:0]];
    if (rt != 5'd0 && int'(rt) < NREGS) rt_val = gpr[rt[RI_W-1:0]];
  end

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R:                                        legal = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
  end

  // Non-R opcodes use the adder for a+sext(imm), which doubles as the lw/sw address.
  always_comb begin
    alu_res = a + imm_s;
    if (op == OP_R) begin
      case (fn)
        FN_SUB:  alu_res = a - b;
        FN_AND:  alu_res = a & b;
        FN_OR:   alu_res = a | b;
        FN_NOR:  alu_res = ~(a | b);
        FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
        default: alu_res = a + b;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      S_FETCH: begin
        if (accept) begin
          state_next = S_DECODE;
          pc_next    = pc + 32'd4;
        end
      end
      S_DECODE: begin
        if (op == OP_J) begin
          pc_next    = {pc[31:28], ir[25:0], 2'b00};
          state_next = S_FETCH;
        end else if (!legal) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_BEQ || op == OP_BNE) begin
          if (taken) pc_next = pc + {imm_s[29:0], 2'b00};
          state_next = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (alu_res[1:0] != 2'b00) state_next = S_HALT;
        else if (accept)           state_next = (op == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
    req_next   = (state_next == S_FETCH) || (state_next == S_MEM && alu_res[1:0] == 2'b00);
    we_next    = (state_next == S_MEM) && (op == OP_SW);
    addr_next  = (state_next == S_MEM) ? alu_res : pc_next;
    wdata_next = we_next ? b : 32'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      instret_q <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      mem_req   <= req_next;
      mem_we    <= we_next;
      mem_addr  <= addr_next[ADDR_W-1:0];
      mem_wdata <= wdata_next;
      if (state == S_FETCH && accept) ir <= mem_rdata;
      if (state == S_DECODE) begin
        a <= rs_val;
        b <= rt_val;
      end
      if (state == S_EXEC) alu_out <= alu_res;
      // Load data replaces the spent address in alu_out so WB has a single source.
      if (state == S_MEM && accept) alu_out <= mem_rdata;
      if (wb_en) gpr[wb_dst[RI_W-1:0]] <= alu_out;
      if (state_next == S_FETCH && state != S_FETCH) instret_q <= instret_q + 32'd1;
    end
  end

  assign halted  = (state == S_HALT);
  assign pc_out  = pc;
  assign instret = instret_q;

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Bench for mips_multicycle_cpu: word memory with programmable wait states, and an
// instruction-level interpreter that predicts memory image, pc, instret and cycle count.
module tb_mips_multicycle_cpu;
  localparam logic [31:0] RPC = 32'h100;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instret;

  int checks = 0;
  int failures = 0;

  logic [31:0] img  [0:1023];
  logic [31:0] dmem [0:1023];
  logic [31:0] rmem [0:1023];
  logic [31:0] rregs [0:31];
  logic [31:0] rpc, rinstret;
  int          rcycles;

  int          wait_mode = 0;
  int          wcnt = 0, wtgt = 0;
  int          cyc, acc_cnt;
  logic [31:0] acc_addr [0:63];
  int          acc_cyc [0:63];
  logic [31:0] st_addr, st_data;

  mips_multicycle_cpu #(.ADDR_W(32), .RESET_PC(RPC), .NREGS(32)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halted(halted), .pc_out(pc_out), .instret(instret)
  );

  always #5 clock = ~clock;

  assign mem_rdata = dmem[mem_addr[11:2]];

  // Memory reloads from img while reset is held; otherwise services accepted transfers.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= img[i];
      cyc     <= 0;
      acc_cnt <= 0;
    end else begin
      cyc <= cyc + 1;
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          dmem[mem_addr[11:2]] <= mem_wdata;
          st_addr <= mem_addr;
          st_data <= mem_wdata;
        end
        if (acc_cnt < 64) begin
          acc_addr[acc_cnt] <= mem_addr;
          acc_cyc[acc_cnt]  <= cyc + 1;
        end
        acc_cnt <= acc_cnt + 1;
      end
    end
  end

  // Each request waits wtgt cycles; ready toggles randomly while no request is pending.
  always @(negedge clock) begin
    if (reset && mem_req) begin
      if (wcnt < wtgt) begin
        mem_ready = 1'b0;
        wcnt++;
      end else begin
        mem_ready = 1'b1;
        wcnt = 0;
        wtgt = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      wcnt = 0;
      wtgt = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = (i >= 512 && i < 576) ? $urandom : 32'd0;
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    img[64 + idx] = w;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic run_dut(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget && timed_out; i++) begin
      tick();
      if (halted) timed_out = 1'b0;
    end
  endtask

  // Instruction-set interpreter; cycles counted from reset release to the HALT entry edge.
  task automatic model_run(input int w);
    logic [31:0] ins, pc4, imm, va, vb, val, ea;
    logic [5:0]  op, f;
    logic [4:0]  rs, rt, rd;
    bit          stop;
    for (int i = 0; i < 1024; i++) rmem[i] = img[i];
    for (int i = 0; i < 32; i++) rregs[i] = 32'd0;
    rpc = RPC; rinstret = 0; rcycles = 1; stop = 1'b0;
    for (int step = 0; step < 4000 && !stop; step++) begin
      ins = rmem[rpc[11:2]];
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; f = ins[5:0];
      imm = {{16{ins[15]}}, ins[15:0]};
      va = rregs[rs]; vb = rregs[rt];
      pc4 = rpc + 4;
      rpc = pc4;
      rcycles += 1 + w;
      val = 32'd0;
      case (op)
        6'h00: begin
          case (f)
            6'h20: val = va + vb;
            6'h22: val = va - vb;
            6'h24: val = va & vb;
            6'h25: val = va | vb;
            6'h27: val = ~(va | vb);
            6'h2A: val = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
            default: stop = 1'b1;
          endcase
          if (stop) rcycles += 1;
          else begin
            if (rd != 0) rregs[rd] = val;
            rcycles += 3; rinstret++;
          end
        end
        6'h08: begin
          if (rt != 0) rregs[rt] = va + imm;
          rcycles += 3; rinstret++;
        end
        6'h02: begin
          rpc = {pc4[31:28], ins[25:0], 2'b00};
          rcycles += 1; rinstret++;
        end
        6'h04, 6'h05: begin
          if ((op == 6'h04) == (va == vb)) rpc = pc4 + (imm << 2);
          rcycles += 2; rinstret++;
        end
        6'h23, 6'h2B: begin
          ea = va + imm;
          if (ea[1:0] != 2'b00) begin
            rcycles += 3; stop = 1'b1;
          end else if (op == 6'h23) begin
            if (rt != 0) rregs[rt] = rmem[ea[11:2]];
            rcycles += 4 + w; rinstret++;
          end else begin
            rmem[ea[11:2]] = vb;
            rcycles += 3 + w; rinstret++;
          end
        end
        default: begin
          rcycles += 1; stop = 1'b1;
        end
      endcase
    end
  endtask

  task automatic test_reset();
    bit to;
    clear_img();
    put(0, HALT_W);
    wait_mode = 0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (pc_out !== RPC) begin failures++; $display("FAIL reset_pc: got %0h want %0h", pc_out, RPC); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b want 0", mem_req); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %0b want 0", halted); end
    checks++; if (instret !== 32'd0) begin failures++; $display("FAIL reset_instret: got %0d want 0", instret); end
    reset = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 10 && to; i++) begin
      tick();
      if (mem_req) to = 1'b0;
    end
    checks++; if (to) begin failures++; $display("FAIL reset_first_req: got timeout want request"); end
    checks++; if (mem_addr !== RPC || mem_we !== 1'b0) begin failures++; $display("FAIL reset_first_addr: got %0h we=%0b want %0h we=0", mem_addr, mem_we, RPC); end
    run_dut(50, to);
    checks++; if (to) begin failures++; $display("FAIL reset_halt_prog: got timeout want halted"); end
  endtask

  task automatic test_alu();
    bit to;
    clear_img();
    put(0, enc_i(6'h08, 5'd1, 5'd0, 16'hFFFB));
    put(1, enc_i(6'h08, 5'd2, 5'd0, 16'd7));
    put(2, enc_r(6'h20, 5'd3, 5'd1, 5'd2));
    put(3, enc_r(6'h2A, 5'd4, 5'd1, 5'd2));
    for (int r = 1; r <= 4; r++) put(3 + r, enc_i(6'h2B, 5'(r), 5'd0, 16'(32'h800 + 4 * r)));
    put(8, HALT_W);
    wait_mode = 0;
    model_run(0);
    do_reset();
    to = 1'b1;
    for (int i = 0; i < 100 && to; i++) begin
      tick();
      if (instret == 32'd4) to = 1'b0;
    end
    checks++; if (to || cyc != 17) begin failures++; $display("FAIL alu_latency: got edge %0d (timeout=%0b) want 17", cyc, to); end
    run_dut(200, to);
    checks++; if (to) begin failures++; $display("FAIL alu_halt: got timeout want halted"); end
    checks++; if (dmem[515] !== 32'd2) begin failures++; $display("FAIL alu_r3: got %0h want 2", dmem[515]); end
    checks++; if (dmem[516] !== 32'd1) begin failures++; $display("FAIL alu_r4: got %0h want 1", dmem[516]); end
    checks++; if (instret !== rinstret) begin failures++; $display("FAIL alu_instret: got %0d want %0d", instret, rinstret); end
    checks++; if (cyc != rcycles) begin failures++; $display("FAIL alu_cycles: got %0d want %0d", cyc, rcycles); end
    for (int i = 512; i < 576; i++) begin
      checks++; if (dmem[i] !== rmem[i]) begin failures++; $display("FAIL alu_mem[%0d]: got %0h want %0h", i, dmem[i], rmem[i]); end
    end
  endtask

  task automatic test_mem_wait();
    bit to;
    int c1;
    clear_img();
    put(0, enc_i(6'h08, 5'd2, 5'd0, 16'd7));
    put(1, enc_i(6'h2B, 5'd2, 5'd0, 16'd8));
    put(2, enc_i(6'h23, 5'd5, 5'd0, 16'd8));
    put(3, enc_i(6'h2B, 5'd5, 5'd0, 16'h0800));
    put(4, HALT_W);
    wait_mode = 3;
    model_run(3);
    do_reset();
    c1 = -1;
    to = 1'b1;
    for (int i = 0; i < 300 && to; i++) begin
      tick();
      if (instret == 32'd1 && c1 < 0) c1 = cyc;
      if (instret == 32'd3) to = 1'b0;
    end
    checks++; if (to || cyc - c1 != 21) begin failures++; $display("FAIL mem_latency: got %0d (timeout=%0b) want 21", cyc - c1, to); end
    checks++; if (st_addr !== 32'd8 || st_data !== 32'd7) begin failures++; $display("FAIL mem_store: got %0h@%0h want 7@8", st_data, st_addr); end
    run_dut(200, to);
    checks++; if (to) begin failures++; $display("FAIL mem_halt: got timeout want halted"); end
    checks++; if (dmem[2] !== 32'd7) begin failures++; $display("FAIL mem_word8: got %0h want 7", dmem[2]); end
    checks++; if (dmem[512] !== 32'd7) begin failures++; $display("FAIL mem_r5: got %0h want 7", dmem[512]); end
    checks++; if (cyc != rcycles || instret !== rinstret) begin failures++; $display("FAIL mem_totals: got cyc=%0d ret=%0d want cyc=%0d ret=%0d", cyc, instret, rcycles, rinstret); end
  endtask

  task automatic test_branch();
    bit to;
    clear_img();
    put(0, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
    wait_mode = 0;
    do_reset();
    to = 1'b1;
    for (int i = 0; i < 100 && to; i++) begin
      tick();
      if (acc_cnt >= 6) to = 1'b0;
    end
    checks++; if (to) begin failures++; $display("FAIL beq_loop: got timeout want 6 fetches"); end
    checks++; if (instret !== 32'd5) begin failures++; $display("FAIL beq_instret: got %0d want 5", instret); end
    for (int k = 1; k < 6; k++) begin
      checks++;
      if (acc_addr[k] !== RPC || acc_cyc[k] - acc_cyc[k-1] != 3) begin
        failures++; $display("FAIL beq_period[%0d]: got %0h after %0d want %0h after 3", k, acc_addr[k], acc_cyc[k] - acc_cyc[k-1], RPC);
      end
    end
    clear_img();
    put(0, enc_i(6'h05, 5'd0, 5'd0, 16'd4));
    put(1, HALT_W);
    put(5, HALT_W);
    do_reset();
    run_dut(50, to);
    checks++; if (to || pc_out !== 32'h108) begin failures++; $display("FAIL bne_not_taken: got pc %0h (timeout=%0b) want 108", pc_out, to); end
    checks++; if (instret !== 32'd1) begin failures++; $display("FAIL bne_instret: got %0d want 1", instret); end
  endtask

  task automatic test_halt();
    bit to;
    clear_img();
    put(0, enc_i(6'h23, 5'd5, 5'd0, 16'd6));
    wait_mode = 0;
    do_reset();
    run_dut(50, to);
    checks++; if (to) begin failures++; $display("FAIL misalign_halt: got timeout want halted"); end
    checks++; if (pc_out !== 32'h104 || instret !== 32'd0) begin failures++; $display("FAIL misalign_state: got pc %0h ret %0d want 104 0", pc_out, instret); end
    checks++; if (acc_cnt != 1 || cyc != 5) begin failures++; $display("FAIL misalign_bus: got %0d transfers edge %0d want 1 and 5", acc_cnt, cyc); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (mem_req !== 1'b0 || halted !== 1'b1 || pc_out !== 32'h104) begin failures++; $display("FAIL halt_absorb[%0d]: got req %0b halted %0b pc %0h want 0 1 104", i, mem_req, halted, pc_out); end
    end
    clear_img();
    put(0, enc_i(6'h08, 5'd1, 5'd0, 16'd1));
    put(1, HALT_W);
    do_reset();
    run_dut(50, to);
    checks++; if (to || pc_out !== 32'h108 || instret !== 32'd1) begin failures++; $display("FAIL op3f: got pc %0h ret %0d timeout %0b want 108 1 0", pc_out, instret, to); end
    clear_img();
    put(0, enc_i(6'h08, 5'd1, 5'd0, 16'd1));
    put(1, enc_r(6'h21, 5'd2, 5'd1, 5'd1));
    do_reset();
    run_dut(50, to);
    checks++; if (to || pc_out !== 32'h108 || instret !== 32'd1) begin failures++; $display("FAIL illegal_funct: got pc %0h ret %0d timeout %0b want 108 1 0", pc_out, instret, to); end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_img();
    for (int r = 1; r <= 7; r++) put(r - 1, enc_i(6'h08, 5'(r), 5'd0, 16'(r * 3 + 1)));
    put(7, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    wait_mode = 8;
    do_reset();
    to = 1'b1;
    for (int i = 0; i < 400 && to; i++) begin
      tick();
      if (instret >= 32'd7 && mem_req && !mem_ready) to = 1'b0;
    end
    checks++; if (to) begin failures++; $display("FAIL midreset_setup: got timeout want stalled request"); end
    clear_img();
    for (int r = 1; r <= 7; r++) put(r - 1, enc_i(6'h2B, 5'(r), 5'd0, 16'(32'h800 + 4 * r)));
    put(7, HALT_W);
    for (int i = 513; i <= 519; i++) img[i] = 32'hDEAD_BEEF;
    reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || pc_out !== RPC || instret !== 32'd0) begin failures++; $display("FAIL midreset_async: got req %0b pc %0h ret %0d want 0 %0h 0", mem_req, pc_out, instret, RPC); end
    wait_mode = 0;
    repeat (3) tick();
    reset = 1'b1;
    run_dut(200, to);
    checks++; if (to || acc_addr[0] !== RPC) begin failures++; $display("FAIL midreset_restart: got first %0h timeout %0b want %0h", acc_addr[0], to, RPC); end
    for (int i = 513; i <= 519; i++) begin
      checks++; if (dmem[i] !== 32'd0) begin failures++; $display("FAIL midreset_gpr[%0d]: got %0h want 0", i - 512, dmem[i]); end
    end
  endtask

  task automatic test_random();
    bit          to;
    int          n, kind, k;
    logic [5:0]  fns [6];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    for (int t = 0; t < 6; t++) begin
      wait_mode = (t % 3 == 0) ? 0 : ((t % 3 == 1) ? -1 : 2);
      clear_img();
      n = int'($urandom_range(16, 24));
      for (int i = 0; i < n; i++) begin
        kind = int'($urandom_range(0, 9));
        k = int'($urandom_range(0, (n - 1 - i) < 3 ? (n - 1 - i) : 3));
        case (kind)
          0, 1, 2: put(i, enc_i(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)));
          3, 4, 5: put(i, enc_r(fns[$urandom_range(0, 5)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))));
          6: put(i, enc_i(6'h2B, 5'($urandom_range(0, 7)), 5'd0, 16'(32'h800 + 4 * $urandom_range(0, 31))));
          7: put(i, enc_i(6'h23, 5'($urandom_range(0, 7)), 5'd0, 16'(32'h800 + 4 * $urandom_range(0, 31))));
          8: put(i, enc_i(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'(k)));
          default: begin
            if (wait_mode < 0) put(i, {6'h02, 26'(64 + i + 1 + k)});
            else put(i, enc_i(6'h08, 5'd1, 5'd1, 16'd1));
          end
        endcase
      end
      for (int r = 1; r <= 7; r++) put(n + r - 1, enc_i(6'h2B, 5'(r), 5'd0, 16'(32'h800 + 4 * (48 + r))));
      put(n + 7, HALT_W);
      model_run(wait_mode < 0 ? 0 : wait_mode);
      do_reset();
      run_dut(3000, to);
      checks++; if (to) begin failures++; $display("FAIL rand%0d_halt: got timeout want halted", t); end
      checks++; if (pc_out !== rpc || instret !== rinstret) begin failures++; $display("FAIL rand%0d_state: got pc %0h ret %0d want pc %0h ret %0d", t, pc_out, instret, rpc, rinstret); end
      if (wait_mode >= 0) begin
        checks++; if (cyc != rcycles) begin failures++; $display("FAIL rand%0d_cycles: got %0d want %0d", t, cyc, rcycles); end
      end
      for (int i = 512; i < 576; i++) begin
        checks++; if (dmem[i] !== rmem[i]) begin failures++; $display("FAIL rand%0d_mem[%0d]: got %0h want %0h", t, i, dmem[i], rmem[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
